pipeline_ctrl: RTL and testbench

- Central sequencer for the five-stage pipeline. Drives the fetch stage's PC-write and branch-redirect inputs, plus the IF/ID and ID/EX write and flush controls.
- Arbitrates four events: data-memory wait, halt, taken branch and load-use hazard. Applies one fixed priority among them.
- Keeps saturating stall and flush performance counters.
- Sits beside the fetch stage. Its inputs come from the ID, EX and MEM stages.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/load_use_detect.sv | 38 +++
 rtl/pipeline_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencer and its helpers.
//   state_t  : sequencer states (IDLE, RUN, MEM_WAIT, HALTED)
//   REG_ZERO : index of the hard-wired zero register x0
//   NOP_INSN : instruction word (addi x0,x0,0) the stage registers load
//              when they are flushed
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      HALTED   = 2'd3
   } state_t;

   localparam int unsigned REG_ZERO = 0;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard compare between the instruction in ID and
// a load sitting in EX. Also reused by the forwarding checks.
// Ports:
//   ex_mem_read  in  EX instruction is a load
//   ex_rd        in  destination register of the EX instruction
//   id_rs1/rs2   in  source registers of the ID instruction
//   id_use_rs1/2 in  ID instruction actually reads that source
//   hazard       out ID needs the load result before it can be forwarded
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module load_use_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   output logic              hazard
);

   // x0 is never really written, so a load targeting it cannot create a
   // dependency even if the ID instruction names x0 as a source.
   logic rd_live;
   logic rs1_match;
   logic rs2_match;

   assign rd_live   = (ex_rd != REG_AW'(REG_ZERO));
   assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
   assign hazard    = ex_mem_read && rd_live && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central sequencer of the five-stage pipeline. Arbitrates data-memory
// wait, halt, taken branch and load-use hazard (in that priority order) and
// drives the fetch, IF/ID and ID/EX controls. Keeps saturating stall and
// flush performance counters.
// Ports:
//   clk, rst_n            pipeline clock, async active-low reset
//   id_rs1/rs2, id_use_*  source operands of the instruction in ID
//   ex_mem_read, ex_rd    load indication / destination of EX instruction
//   ex_branch_taken       EX resolved a taken branch/jump
//   ex_branch_target      redirect target
//   ex_halt               EX holds a halt/ecall
//   mem_busy              data memory not ready this cycle
//   pc_write              fetch PC advances by 4
//   branch, branch_pc     fetch loads branch_pc (only while pc_write=0)
//   if_id_write/flush     IF/ID capture / load NOP
//   id_ex_flush           ID/EX loads a bubble
//   pipe_stall            freeze ID/EX, EX/MEM, MEM/WB
//   halted                core halted (sticky until reset)
//   stall_cnt, flush_cnt  saturating performance counters
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_branch_taken,
   input  logic [XLEN-1:0]   ex_branch_target,
   input  logic              ex_halt,
   input  logic              mem_busy,
   output logic              pc_write,
   output logic              branch,
   output logic [XLEN-1:0]   branch_pc,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              pipe_stall,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state;
   state_t next_state;
   logic   hazard;
   logic   active;

   load_use_detect #(
      .REG_AW (REG_AW)
   ) u_load_use (
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .hazard      (hazard)
   );

   assign active = (state == RUN) || (state == MEM_WAIT);

   // Decision table shared by RUN and MEM_WAIT. A busy data memory masks
   // everything else so a pending branch or halt is simply re-evaluated
   // once memory is ready. A branch outranks the load-use hazard because
   // the hazarding instruction is flushed anyway.
   always_comb begin
      next_state  = state;
      pc_write    = 1'b0;
      branch      = 1'b0;
      branch_pc   = '0;
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_stall  = 1'b0;
      halted      = 1'b0;
      case (state)
         IDLE: begin
            next_state = RUN;
         end
         RUN, MEM_WAIT: begin
            if (mem_busy) begin
               pipe_stall = 1'b1;
               next_state = MEM_WAIT;
            end else if (ex_halt) begin
               id_ex_flush = 1'b1;
               next_state  = HALTED;
            end else if (ex_branch_taken) begin
               branch      = 1'b1;
               branch_pc   = ex_branch_target;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               next_state  = RUN;
            end else if (hazard) begin
               id_ex_flush = 1'b1;
               next_state  = RUN;
            end else begin
               pc_write    = 1'b1;
               if_id_write = 1'b1;
               next_state  = RUN;
            end
         end
         HALTED: begin
            halted = 1'b1;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register plus saturating counters. Counters only move while the
   // sequencer is actively running, so they freeze in IDLE and HALTED.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= next_state;
         if (active && !pc_write && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (branch && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed self-checking bench for pipeline_ctrl. Inputs change on the
// falling edge; combinational outputs are sampled 1ns later, registered
// counters are sampled one falling edge after the rising edge that
// updated them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_ctrl;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic        ex_halt;
   logic        mem_busy;
   logic        pc_write;
   logic        branch;
   logic [31:0] branch_pc;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        pipe_stall;
   logic        halted;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int compared   = 0;
   int mismatched = 0;

   pipeline_ctrl #(
      .XLEN   (32),
      .REG_AW (5),
      .CNT_W  (16)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .id_rs1           (id_rs1),
      .id_rs2           (id_rs2),
      .id_use_rs1       (id_use_rs1),
      .id_use_rs2       (id_use_rs2),
      .ex_mem_read      (ex_mem_read),
      .ex_rd            (ex_rd),
      .ex_branch_taken  (ex_branch_taken),
      .ex_branch_target (ex_branch_target),
      .ex_halt          (ex_halt),
      .mem_busy         (mem_busy),
      .pc_write         (pc_write),
      .branch           (branch),
      .branch_pc        (branch_pc),
      .if_id_write      (if_id_write),
      .if_id_flush      (if_id_flush),
      .id_ex_flush      (id_ex_flush),
      .pipe_stall       (pipe_stall),
      .halted           (halted),
      .stall_cnt        (stall_cnt),
      .flush_cnt        (flush_cnt)
   );

   // 10ns pipeline clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "[TB] timeout");
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Drive one cycle worth of inputs on the falling edge, then settle
   task automatic applyStimulus(input logic busy, input logic halt,
                                input logic br, input logic [31:0] tgt,
                                input logic mrd, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2);
      @(negedge clk);
      mem_busy         = busy;
      ex_halt          = halt;
      ex_branch_taken  = br;
      ex_branch_target = tgt;
      ex_mem_read      = mrd;
      ex_rd            = rd;
      id_rs1           = rs1;
      id_rs2           = rs2;
      id_use_rs1       = u1;
      id_use_rs2       = u2;
      #1;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   // Reset pulse, leaves the DUT in its IDLE cycle sampled 1ns after release
   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      mem_busy = 1'b0; ex_halt = 1'b0; ex_branch_taken = 1'b0;
      ex_branch_target = 32'h0; ex_mem_read = 1'b0; ex_rd = 5'd0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_idle_pc_write", 32'(pc_write), 0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt), 0);
      checkOutput("rst_flush_cnt", 32'(flush_cnt), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      mem_busy = 1'b0; ex_halt = 1'b0; ex_branch_taken = 1'b0;
      ex_branch_target = 32'h0; ex_mem_read = 1'b0; ex_rd = 5'd0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;

      // Reset held for three cycles
      repeat (3) @(negedge clk);
      #1;
      checkOutput("inrst_pc_write", 32'(pc_write), 0);
      checkOutput("inrst_halted", 32'(halted), 0);
      checkOutput("inrst_branch_pc", branch_pc, 0);
      rst_n = 1'b1;
      #1;
      // IDLE cycle: everything low
      checkOutput("idle_pc_write", 32'(pc_write), 0);
      checkOutput("idle_if_id_write", 32'(if_id_write), 0);
      checkOutput("idle_pipe_stall", 32'(pipe_stall), 0);
      idleInputs();
      checkOutput("run_pc_write", 32'(pc_write), 1);
      checkOutput("run_if_id_write", 32'(if_id_write), 1);
      checkOutput("run_stall_cnt", 32'(stall_cnt), 0);
      checkOutput("run_flush_cnt", 32'(flush_cnt), 0);

      // Load-use on rs2: one-cycle stall with ID/EX bubble
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
      checkOutput("lu_pc_write", 32'(pc_write), 0);
      checkOutput("lu_if_id_write", 32'(if_id_write), 0);
      checkOutput("lu_id_ex_flush", 32'(id_ex_flush), 1);
      checkOutput("lu_branch", 32'(branch), 0);
      idleInputs();
      checkOutput("lu_after_pc_write", 32'(pc_write), 1);
      checkOutput("lu_stall_cnt", 32'(stall_cnt), 1);

      // Load into x0 never stalls
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      checkOutput("x0_pc_write", 32'(pc_write), 1);
      checkOutput("x0_id_ex_flush", 32'(id_ex_flush), 0);
      idleInputs();
      checkOutput("x0_stall_cnt", 32'(stall_cnt), 1);

      // Load-use on rs1 with rs2 unused
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
      checkOutput("lu1_pc_write", 32'(pc_write), 0);
      // Matching register but not read: no hazard
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0);
      checkOutput("nouse_pc_write", 32'(pc_write), 1);
      checkOutput("lu1_stall_cnt", 32'(stall_cnt), 2);

      // Branch and hazard in the same cycle resolve as a branch
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      checkOutput("bh_branch", 32'(branch), 1);
      checkOutput("bh_branch_pc", branch_pc, 32'h40);
      checkOutput("bh_if_id_flush", 32'(if_id_flush), 1);
      checkOutput("bh_id_ex_flush", 32'(id_ex_flush), 1);
      checkOutput("bh_pc_write", 32'(pc_write), 0);
      idleInputs();
      checkOutput("bh_flush_cnt", 32'(flush_cnt), 1);
      checkOutput("bh_stall_cnt", 32'(stall_cnt), 3);
      checkOutput("bh_after_branch", 32'(branch), 0);
      checkOutput("bh_after_branch_pc", branch_pc, 0);

      // mem_busy masks a pending branch for four cycles
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         checkOutput("mw_pipe_stall", 32'(pipe_stall), 1);
         checkOutput("mw_branch", 32'(branch), 0);
         checkOutput("mw_pc_write", 32'(pc_write), 0);
         checkOutput("mw_branch_pc", branch_pc, 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("mw_rel_branch", 32'(branch), 1);
      checkOutput("mw_rel_branch_pc", branch_pc, 32'h80);
      checkOutput("mw_rel_pipe_stall", 32'(pipe_stall), 0);
      idleInputs();
      checkOutput("mw_run_pc_write", 32'(pc_write), 1);
      checkOutput("mw_stall_cnt", 32'(stall_cnt), 5);
      checkOutput("mw_flush_cnt", 32'(flush_cnt), 1);

      // Halt, then ignore everything until reset
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("ht_pc_write", 32'(pc_write), 0);
      checkOutput("ht_id_ex_flush", 32'(id_ex_flush), 1);
      checkOutput("ht_halted_early", 32'(halted), 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("ht_halted", 32'(halted), 1);
      checkOutput("ht_pipe_stall", 32'(pipe_stall), 0);
      checkOutput("ht_branch", 32'(branch), 0);
      checkOutput("ht_id_ex_flush_q", 32'(id_ex_flush), 0);
      checkOutput("ht_if_id_write", 32'(if_id_write), 0);
      checkOutput("ht_stall_cnt", 32'(stall_cnt), 6);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("ht_stall_frozen", 32'(stall_cnt), 6);
      checkOutput("ht_flush_frozen", 32'(flush_cnt), 1);
      // Async reset pulse in the middle of a cycle
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_halted", 32'(halted), 0);
      checkOutput("ar_stall_cnt", 32'(stall_cnt), 0);
      checkOutput("ar_flush_cnt", 32'(flush_cnt), 0);
      checkOutput("ar_pipe_stall", 32'(pipe_stall), 0);

      // Counter saturation with a continuous stream of redirects
      doReset();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      repeat (65534) @(negedge clk);
      #1;
      checkOutput("sat_flush_pre", 32'(flush_cnt), 32'hFFFE);
      checkOutput("sat_stall_pre", 32'(stall_cnt), 32'hFFFE);
      repeat (5) @(negedge clk);
      #1;
      checkOutput("sat_flush_cnt", 32'(flush_cnt), 32'hFFFF);
      checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
      checkOutput("sat_branch", 32'(branch), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
